proj_sorter_reader: RTL and testbench



---
 rtl/proj_sorter_reader.sv | 143 ++++++++++++++
 tb/tb_proj_sorter_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_sorter_reader.sv
// proj_sorter_reader
//
// Reader side of the sorter result interface. When the sorter raises
// in_sort_valid, the whole vector of the smallest-signature indices is
// captured into a local buffer. The buffer is then streamed one index per
// transfer, lowest signature first, over a valid/ready handshake. The block
// holds one complete result. A new result that arrives while a result is
// still draining is dropped, and the sticky out_overrun flag is set.
//
// Ports
//   in_clk           clock, all state updates on the rising edge
//   in_rst           asynchronous active-high reset
//   in_smallest_idx  sorted index vector, entry 0 = smallest signature
//   in_sort_valid    level, high while in_smallest_idx is valid
//   out_index        index currently offered on the stream (0 when idle)
//   out_position     rank of out_index (0 when idle)
//   out_valid        stream item valid
//   in_ready         downstream accepts the item when high
//   out_last         current item is the final rank
//   out_done         one-cycle pulse after the final transfer
//   out_overrun      sticky, set when a result was dropped

package proj_pkg;
    localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int INDICE_LEN                    = 8;
endpackage

module proj_sorter_reader #(
    parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int POS_LEN       = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1
) (
    input  logic                                     in_clk,
    input  logic                                     in_rst,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
    input  logic                                     in_sort_valid,
    output logic [INDICE_LEN-1:0]                    out_index,
    output logic [POS_LEN-1:0]                       out_position,
    output logic                                     out_valid,
    input  logic                                     in_ready,
    output logic                                     out_last,
    output logic                                     out_done,
    output logic                                     out_overrun
);

    // state | meaning
    // IDLE  | no result buffered, waiting for a capture event
    // SEND  | buffered result is being streamed, rank = pos_q
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [POS_LEN-1:0] LAST_POS = POS_LEN'(INDICES_COUNT - 1);

    state_t                                 state_q, state_d;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] buffer_q, buffer_d;
    logic [POS_LEN-1:0]                     pos_q, pos_d;
    logic                                   sv_prev_q;
    logic                                   done_q, done_d;
    logic                                   overrun_q, overrun_d;

    logic capture;
    logic final_xfer;

    // A capture event is a rising edge of in_sort_valid; holding the level
    // high therefore yields a single event.
    assign capture    = in_sort_valid && !sv_prev_q;
    assign final_xfer = (state_q == SEND) && in_ready && (pos_q == LAST_POS);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= IDLE;
            buffer_q  <= '0;
            pos_q     <= '0;
            sv_prev_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buffer_q  <= buffer_d;
            pos_q     <= pos_d;
            sv_prev_q <= in_sort_valid;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buffer_d  = buffer_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    buffer_d = in_smallest_idx;
                    pos_d    = '0;
                    state_d  = SEND;
                end
            end

            SEND: begin
                if (in_ready) begin
                    if (pos_q == LAST_POS) begin
                        done_d = 1'b1;
                        // A result landing exactly on the final transfer
                        // can be accepted without a gap cycle.
                        if (capture) begin
                            buffer_d = in_smallest_idx;
                            pos_d    = '0;
                        end else begin
                            state_d = IDLE;
                            pos_d   = '0;
                        end
                    end else begin
                        pos_d = pos_q + POS_LEN'(1);
                    end
                end
                // Any other capture while draining would corrupt the result
                // in flight, so it is dropped and flagged.
                if (capture && !final_xfer) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                pos_d   = '0;
            end
        endcase
    end

    assign out_valid    = (state_q == SEND);
    assign out_index    = out_valid ? buffer_q[pos_q] : '0;
    assign out_position = out_valid ? pos_q : '0;
    assign out_last     = out_valid && (pos_q == LAST_POS);
    assign out_done     = done_q;
    assign out_overrun  = overrun_q;

endmodule

// File: tb/tb_proj_sorter_reader.sv
// Testbench for proj_sorter_reader (INDICES_COUNT=4, INDICE_LEN=8).
// Expected stream items are queued when a result is loaded; a monitor on
// the falling edge pops and compares every accepted transfer.

module tb_proj_sorter_reader;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PL = 2;

    logic                  clk;
    logic                  rst;
    logic [N-1:0][W-1:0]   smallest_idx;
    logic                  sort_valid;
    logic [W-1:0]          index;
    logic [PL-1:0]         position;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic                  done;
    logic                  overrun;

    typedef struct packed {
        logic [W-1:0]  idx;
        logic [PL-1:0] pos;
        logic          lst;
    } item_t;

    item_t sb[$];
    int    checks  = 0;
    int    errors  = 0;
    int    pushed  = 0;
    int    popped  = 0;

    proj_sorter_reader #(
        .INDICES_COUNT(N),
        .INDICE_LEN   (W),
        .POS_LEN      (PL)
    ) dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_smallest_idx (smallest_idx),
        .in_sort_valid   (sort_valid),
        .out_index       (index),
        .out_position    (position),
        .out_valid       (valid),
        .in_ready        (ready),
        .out_last        (last),
        .out_done        (done),
        .out_overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {valid, index, position, last, done, overrun}, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [N-1:0][W-1:0] v);
        for (int i = 0; i < N; i++) begin
            item_t it;
            it.idx = v[i];
            it.pos = PL'(i);
            it.lst = (i == N - 1);
            sb.push_back(it);
            pushed++;
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever
    // valid && ready are seen here.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got index 0x%0h pos %0d, expected no transfer at %0t",
                         index, position, $time);
            end else begin
                item_t e;
                e = sb.pop_front();
                popped++;
                chk("xfer_item", {index, position, last}, {e.idx, e.pos, e.lst});
            end
        end
    end

    logic [N-1:0][W-1:0] res_a, res_b, res_c;

    initial begin
        res_a = {8'h44, 8'h33, 8'h22, 8'h11};
        res_b = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        res_c = {8'h5E, 8'h4D, 8'h3C, 8'h2B};

        rst          = 1'b1;
        sort_valid   = 1'b0;
        ready        = 1'b1;
        smallest_idx = '0;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("reset_outputs");
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle("idle_outputs");
        end

        // Basic drain
        smallest_idx = res_a;
        sort_valid   = 1'b1;
        push_result(res_a);
        step();
        sort_valid = 1'b0;
        chk("basic_latency", {valid, index, position}, {1'b1, 8'h11, 2'd0});
        for (int i = 0; i < N; i++) step();
        chk("basic_done", {done, valid}, {1'b1, 1'b0});
        step();
        chk("basic_done_pulse", {done, valid}, {1'b0, 1'b0});

        // Backpressure on rank 1
        sort_valid = 1'b1;
        push_result(res_a);
        step();
        sort_valid = 1'b0;
        step();
        ready = 1'b0;
        chk("bp_hold", {valid, index, position, last}, {1'b1, 8'h22, 2'd1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold", {valid, index, position, last}, {1'b1, 8'h22, 2'd1, 1'b0});
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("bp_done", {done, valid}, {1'b1, 1'b0});

        // Overrun and input isolation
        step();
        sort_valid = 1'b1;
        push_result(res_a);
        step();
        sort_valid = 1'b0;
        step();
        chk("ovr_rank1", {index, position}, {8'h22, 2'd1});
        smallest_idx = res_b;
        sort_valid   = 1'b1;
        step();
        sort_valid = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        for (int i = 0; i < 2; i++) step();
        chk("ovr_done", {done, valid}, {1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovr_sticky_idle", {overrun, valid}, {1'b1, 1'b0});
        end

        // Reset clears the sticky flag
        rst = 1'b1;
        #1;
        chk_idle("ovr_reset_clear");
        step();
        rst = 1'b0;
        step();

        // Held level: exactly one result
        smallest_idx = res_a;
        sort_valid   = 1'b1;
        push_result(res_a);
        step();
        for (int i = 0; i < N; i++) step();
        chk("held_done", {done, valid}, {1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_repeat", valid, 1'b0);
        end
        sort_valid = 1'b0;
        step();

        // Back-to-back: new capture on the final-transfer edge
        sort_valid = 1'b1;
        push_result(res_a);
        step();
        sort_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("b2b_rank3", {index, position, last}, {8'h44, 2'd3, 1'b1});
        smallest_idx = res_b;
        sort_valid   = 1'b1;
        push_result(res_b);
        step();
        chk("b2b_seam", {done, valid, position, index, overrun},
            {1'b1, 1'b1, 2'd0, 8'hAA, 1'b0});
        sort_valid = 1'b0;
        for (int i = 0; i < N; i++) step();
        chk("b2b_done", {done, valid, overrun}, {1'b1, 1'b0, 1'b0});
        step();

        // Reset mid-stream at rank 2
        smallest_idx = res_c;
        sort_valid   = 1'b1;
        push_result(res_c);
        step();
        sort_valid = 1'b0;
        step();
        step();
        chk("mid_rank2", {index, position}, {8'h4D, 2'd2});
        #2;
        rst = 1'b1;
        #1;
        chk_idle("mid_async_reset");
        chk("mid_pending", sb.size(), 32'd2);
        pushed -= sb.size();
        sb.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("mid_after_release");
        end
        sort_valid = 1'b1;
        push_result(res_c);
        step();
        sort_valid = 1'b0;
        chk("mid_restart", {valid, index, position}, {1'b1, 8'h2B, 2'd0});
        for (int i = 0; i < N; i++) step();
        chk("mid_restart_done", {done, valid}, {1'b1, 1'b0});

        for (int i = 0; i < 3; i++) step();
        chk("sb_empty", sb.size(), 32'd0);
        chk("xfer_count", popped, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
